fwd_ctrl_unit: RTL and testbench
================================

Name: fwd_ctrl_unit

Overview:
- Control-side counterpart of the 3:1 forwarding operand muxes in the pipelined CPU. It produces the 2-bit select codes those muxes consume.
- Tracks in-flight destination registers through the EX, MEM and WB stages in its own shadow pipeline registers.
- Detects load-use hazards and issues stall/bubble control.
- Sits beside the ID/EX/MEM/WB pipeline registers and is fed from decode.

Parameters:
REG_AW, 5, register-index width
CNT_W, 16, width of saturating stall counter

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
id_valid_i  input  1  ID stage holds a real instruction
id_rs1_i  input  REG_AW  ID source register 1
id_rs2_i  input  REG_AW  ID source register 2
id_rd_i  input  REG_AW  ID destination register
id_regwrite_i  input  1  ID instruction writes rd
id_memread_i  input  1  ID instruction is a load
flush_i  input  1  branch taken: instruction leaving ID is squashed
fwd_a_o  output  2  select for ALU operand A mux
fwd_b_o  output  2  select for ALU operand B mux
stall_o  output  1  hold PC and IF/ID; insert bubble into EX
stall_cnt_o  output  CNT_W  count of stall cycles, saturating

Behaviour:
- Select encoding, fixed:
  - 00 = register-file value from ID/EX.
  - 01 = MEM/WB write-back value.
  - 10 = EX/MEM ALU result.
  - 11 is never driven.
- Shadow stages, each an entry of {valid, rs1, rs2, rd, regwrite, memread}: EX, MEM, WB. MEM and WB use rd/regwrite/memread only.
- Every rising edge, all stages advance together:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= bubble if (stall_o | flush_i | ~id_valid_i), else the ID inputs.
- A bubble has valid=0, regwrite=0, memread=0, and all indices 0.
- Reset, asynchronous, rst_n_i=0: all stages become bubbles and stall_cnt_o=0.
  - Outputs then settle to fwd_a_o=00, fwd_b_o=00, stall_o=0 with no clock edge needed.
  - Reset asserted mid-stall drops stall_o immediately.
- Forwarding, combinational from the registered stage state (zero-cycle latency relative to the EX stage). For operand A, using EX.rs1:
  - 10 if MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs1.
  - else 01 if WB.regwrite & WB.rd!=0 & WB.rd==EX.rs1.
  - else 00.
  - MEM has priority over WB when both match, so the newest value wins.
  - Operand B is identical using EX.rs2.
  - EX.valid=0 forces 00.
- Register x0 is never forwarded, whatever the regwrite state.
- Load-use stall, combinational:
  - stall_o = id_valid_i & EX.memread & EX.rd!=0 & (EX.rd==id_rs1_i | EX.rd==id_rs2_i).
  - A stall lasts exactly 1 cycle per hazard. On the next cycle the load sits in MEM as a bubble-separated producer and resolves via select 01 one cycle later.
- A load in MEM is never forwarded with 10. A load can only reach MEM directly behind its consumer if the stall was bypassed, which cannot happen by construction.
- flush_i and stall_o in the same cycle: a bubble enters EX; stall_o is still reported; the counter still increments.
- stall_cnt_o increments by 1 on each edge where stall_o=1. It saturates at 2^CNT_W-1 and does not wrap.
- All sequential state lives in a single always block, sensitive to posedge clk_i and negedge rst_n_i.

Decomposition:
- Shared cpu_pkg holds:
  - Constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_AW.
  - A stage-entry struct typedef {valid, rs1, rs2, rd, regwrite, memread}.
- One natural sub-module: fwd_sel. It is a pure comparator that takes one source index plus the MEM/WB rd/regwrite and returns the 2-bit select. It is instantiated twice, for A and B.

Test Plan:
- Back-to-back ALU ops: add x5 then sub using rs1=x5 -> fwd_a_o=10 in the consumer's EX cycle, stall_o=0.
- Producer two ahead: add x7, a nop, then an op with rs2=x7 -> fwd_b_o=01. If both MEM and WB write x7 -> 10 (priority).
- Load-use: lw x9 then add with rs1=x9 -> stall_o=1 for exactly 1 cycle, EX receives a bubble, then fwd_a_o=01; stall_cnt_o goes 0->1.
- Writes to x0: addi x0 then an op with rs1=x0 -> fwd_a_o=00; lw x0 then use of x0 -> stall_o=0.
- Flush: flush_i=1 with a matching ID instruction -> next cycle fwd_a_o=00 and fwd_b_o=00 for the squashed slot.
- Reset mid-stall: assert rst_n_i=0 while stall_o=1 -> stall_o=0, both fwd selects 00 and stall_cnt_o=0 with no clock edge. Separately, force 2^16 stalls -> counter holds at 16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline types and forwarding select codes
package cpu_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - forwarding select for one ALU operand source index
module fwd_sel
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        sel
);

    // MEM is checked first so the newest producer wins; x0 is never a producer
    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_ctrl_unit.sv
// rtl/fwd_ctrl_unit.sv - operand forwarding selects and load-use stall control
module fwd_ctrl_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    cpu_pkg::stage_t  ex_q;
    cpu_pkg::stage_t  mem_q;
    cpu_pkg::stage_t  wb_q;
    cpu_pkg::stage_t  id_entry;
    logic             bubble_in;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic [CNT_W-1:0] cnt_q;
    logic             unused_fields;

    // Pack the decode-stage fields into a shadow-stage entry
    always_comb begin
        id_entry          = cpu_pkg::STAGE_BUBBLE;
        id_entry.valid    = id_valid_i;
        id_entry.rs1      = id_rs1_i;
        id_entry.rs2      = id_rs2_i;
        id_entry.rd       = id_rd_i;
        id_entry.regwrite = id_regwrite_i;
        id_entry.memread  = id_memread_i;
    end

    // Load in EX whose result the ID instruction needs: hold ID for one cycle
    always_comb begin
        stall_o   = id_valid_i && ex_q.memread && (ex_q.rd != '0) &&
                    ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));
        bubble_in = stall_o || flush_i || !id_valid_i;
    end

    // Shadow pipeline advance and saturating stall counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_q  <= cpu_pkg::STAGE_BUBBLE;
            mem_q <= cpu_pkg::STAGE_BUBBLE;
            wb_q  <= cpu_pkg::STAGE_BUBBLE;
            cnt_q <= '0;
        end else begin
            ex_q  <= bubble_in ? cpu_pkg::STAGE_BUBBLE : id_entry;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (stall_o && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    fwd_sel u_sel_a (
        .src          (ex_q.rs1),
        .mem_rd       (mem_q.rd),
        .mem_regwrite (mem_q.regwrite),
        .wb_rd        (wb_q.rd),
        .wb_regwrite  (wb_q.regwrite),
        .sel          (sel_a)
    );

    fwd_sel u_sel_b (
        .src          (ex_q.rs2),
        .mem_rd       (mem_q.rd),
        .mem_regwrite (mem_q.regwrite),
        .wb_rd        (wb_q.rd),
        .wb_regwrite  (wb_q.regwrite),
        .sel          (sel_b)
    );

    // An empty EX slot has no operands to forward
    always_comb begin
        fwd_a_o = ex_q.valid ? sel_a : cpu_pkg::FWD_RF;
        fwd_b_o = ex_q.valid ? sel_b : cpu_pkg::FWD_RF;
    end

    assign stall_cnt_o = cnt_q;

    // MEM/WB only need rd/regwrite; the rest of the entry rides along unused
    assign unused_fields = ^{mem_q.valid, mem_q.rs1, mem_q.rs2, mem_q.memread,
                             wb_q.valid, wb_q.rs1, wb_q.rs2, wb_q.memread};

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// tb/tb_fwd_ctrl_unit.sv - self-checking bench for fwd_ctrl_unit
module tb_fwd_ctrl_unit;

    localparam int AW    = 5;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mr;
    } instr_t;

    typedef struct {
        instr_t    ins;
        logic      fl;
        int        ea;
        int        eb;
        int        es;
        int        ec;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0;
    logic [AW-1:0] id_rs2 = '0;
    logic [AW-1:0] id_rd = '0;
    logic          id_regwrite = 1'b0;
    logic          id_memread = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          stall;
    logic [CW-1:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Issued-instruction history: hist[0] newest (in EX), hist[1] MEM, hist[2] WB
    instr_t hist[3];
    int     m_cnt;

    vec_t tbl[23];

    fwd_ctrl_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_regwrite),
        .id_memread_i  (id_memread),
        .flush_i       (flush),
        .fwd_a_o       (fwd_a),
        .fwd_b_o       (fwd_b),
        .stall_o       (stall),
        .stall_cnt_o   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic instr_t mk(input int v, input int rs1, input int rs2,
                                  input int rd, input int rw, input int mr);
        instr_t i;
        i.v   = v[0];
        i.rs1 = rs1[AW-1:0];
        i.rs2 = rs2[AW-1:0];
        i.rd  = rd[AW-1:0];
        i.rw  = rw[0];
        i.mr  = mr[0];
        return i;
    endfunction

    function automatic vec_t mv(input instr_t ins, input int fl, input int ea,
                                input int eb, input int es, input int ec);
        vec_t t;
        t.ins = ins;
        t.fl  = fl[0];
        t.ea  = ea;
        t.eb  = eb;
        t.es  = es;
        t.ec  = ec;
        return t;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) hist[k] = '0;
        m_cnt = 0;
    endfunction

    // Newest writer of src wins: one instruction back (MEM) gives 2, two back (WB) gives 1
    function automatic int exp_sel(input logic [AW-1:0] src);
        if (!hist[0].v) return 0;
        if (hist[1].rw && hist[1].rd != 0 && hist[1].rd == src) return 2;
        if (hist[2].rw && hist[2].rd != 0 && hist[2].rd == src) return 1;
        return 0;
    endfunction

    function automatic int exp_stall(input instr_t id);
        if (!id.v || !hist[0].mr || hist[0].rd == 0) return 0;
        return (hist[0].rd == id.rs1 || hist[0].rd == id.rs2) ? 1 : 0;
    endfunction

    // One clock: drive ID, check outputs against the model, then retire the cycle
    task automatic step(input instr_t id, input logic fl, input string nm);
        int es;
        @(negedge clk);
        id_valid    = id.v;
        id_rs1      = id.rs1;
        id_rs2      = id.rs2;
        id_rd       = id.rd;
        id_regwrite = id.rw;
        id_memread  = id.mr;
        flush       = fl;
        #1;
        es = exp_stall(id);
        chk({nm, ".fwd_a"}, int'(fwd_a), exp_sel(hist[0].rs1));
        chk({nm, ".fwd_b"}, int'(fwd_b), exp_sel(hist[0].rs2));
        chk({nm, ".stall"}, int'(stall), es);
        chk({nm, ".cnt"}, int'(stall_cnt), m_cnt);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = (es != 0 || fl || !id.v) ? instr_t'('0) : id;
        if (es != 0 && m_cnt < CMAX) m_cnt++;
    endtask

    instr_t nop;
    instr_t lw9;
    instr_t use9;
    instr_t r;

    initial begin
        nop  = mk(0, 0, 0, 0, 0, 0);
        lw9  = mk(1, 2, 0, 9, 1, 1);
        use9 = mk(1, 9, 3, 11, 1, 0);

        tbl[0]  = mv(mk(1, 1, 2, 5, 1, 0),   0, 0, 0, 0, 0);
        tbl[1]  = mv(mk(1, 5, 3, 6, 1, 0),   0, 0, 0, 0, 0);
        tbl[2]  = mv(nop,                    0, 2, 0, 0, 0);
        tbl[3]  = mv(mk(1, 0, 0, 7, 1, 0),   0, 0, 0, 0, 0);
        tbl[4]  = mv(nop,                    0, 0, 0, 0, 0);
        tbl[5]  = mv(mk(1, 1, 7, 9, 1, 0),   0, 0, 0, 0, 0);
        tbl[6]  = mv(nop,                    0, 0, 1, 0, 0);
        tbl[7]  = mv(mk(1, 0, 0, 7, 1, 0),   0, 0, 0, 0, 0);
        tbl[8]  = mv(mk(1, 0, 0, 7, 1, 0),   0, 0, 0, 0, 0);
        tbl[9]  = mv(mk(1, 7, 7, 10, 1, 0),  0, 0, 0, 0, 0);
        tbl[10] = mv(nop,                    0, 2, 2, 0, 0);
        tbl[11] = mv(lw9,                    0, 0, 0, 0, 0);
        tbl[12] = mv(use9,                   0, 0, 0, 1, 0);
        tbl[13] = mv(use9,                   0, 0, 0, 0, 1);
        tbl[14] = mv(nop,                    0, 1, 0, 0, 1);
        tbl[15] = mv(mk(1, 0, 0, 0, 1, 0),   0, 0, 0, 0, 1);
        tbl[16] = mv(mk(1, 0, 0, 12, 1, 0),  0, 0, 0, 0, 1);
        tbl[17] = mv(nop,                    0, 0, 0, 0, 1);
        tbl[18] = mv(mk(1, 3, 0, 0, 1, 1),   0, 0, 0, 0, 1);
        tbl[19] = mv(mk(1, 0, 0, 14, 1, 0),  0, 0, 0, 0, 1);
        tbl[20] = mv(mk(1, 0, 0, 13, 1, 0),  0, 0, 0, 0, 1);
        tbl[21] = mv(mk(1, 13, 13, 15, 1, 0), 1, 0, 0, 0, 1);
        tbl[22] = mv(nop,                    0, 0, 0, 0, 1);

        model_reset();

        // Reset state, before any clock edge
        #1;
        chk("reset.fwd_a", int'(fwd_a), 0);
        chk("reset.fwd_b", int'(fwd_b), 0);
        chk("reset.stall", int'(stall), 0);
        chk("reset.cnt", int'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: hand-derived expectations plus model checks
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].ins, tbl[i].fl, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.hand_a", i), int'(fwd_a), tbl[i].ea);
            chk($sformatf("tbl%0d.hand_b", i), int'(fwd_b), tbl[i].eb);
            chk($sformatf("tbl%0d.hand_stall", i), int'(stall), tbl[i].es);
            chk($sformatf("tbl%0d.hand_cnt", i), int'(stall_cnt), tbl[i].ec);
        end

        // Flush and stall together: stall still reported, counter still counts
        step(lw9, 1'b0, "fs_load");
        step(use9, 1'b1, "fs_use");
        chk("fs_use.hand_stall", int'(stall), 1);
        step(nop, 1'b0, "fs_after");
        chk("fs_after.hand_cnt", int'(stall_cnt), 2);
        chk("fs_after.hand_a", int'(fwd_a), 0);

        // Reset asserted while stalling clears everything without a clock edge
        step(nop, 1'b0, "rs_pad");
        step(lw9, 1'b0, "rs_load");
        @(negedge clk);
        id_valid    = use9.v;
        id_rs1      = use9.rs1;
        id_rs2      = use9.rs2;
        id_rd       = use9.rd;
        id_regwrite = use9.rw;
        id_memread  = use9.mr;
        flush       = 1'b0;
        #1;
        chk("rs.stall_before", int'(stall), 1);
        rst_n = 1'b0;
        #1;
        chk("rs.stall_async", int'(stall), 0);
        chk("rs.fwd_a_async", int'(fwd_a), 0);
        chk("rs.fwd_b_async", int'(fwd_b), 0);
        chk("rs.cnt_async", int'(stall_cnt), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic over a small register range so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            r.v   = ($urandom_range(0, 9) < 8);
            r.rs1 = AW'($urandom_range(0, 3));
            r.rs2 = AW'($urandom_range(0, 3));
            r.rd  = AW'($urandom_range(0, 3));
            r.rw  = ($urandom_range(0, 9) < 6);
            r.mr  = ($urandom_range(0, 9) < 3);
            step(r, ($urandom_range(0, 9) == 0), "rnd");
        end

        // Saturation: a repeating self-dependent load stalls every other cycle
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step(mk(1, 9, 9, 9, 1, 1), 1'b0, "sat");
        end
        chk("sat.hand_cnt", int'(stall_cnt), CMAX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
